// File: rtl/fht_pkg.sv
// fht_pkg: shared FSM state type and elaboration-time math helpers for the FHT sequencer
package fht_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam real PI = 3.14159265358979323846;
  function automatic int max_w(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int round_int(input real x);
    return x < 0.0 ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
  endfunction
endpackage

// File: rtl/fht_twiddle_rom.sv
// fht_twiddle_rom: cos/sin coefficient table with RD_LAT registered stages
module fht_twiddle_rom #(
  parameter int LOG2N  = 4,
  parameter int W_BIT  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [LOG2N-2:0]        idx,
  output logic signed [W_BIT-1:0] cos,
  output logic signed [W_BIT-1:0] sin,
  output logic                    vld
);
  import fht_pkg::*;
  localparam int HALF = 1 << (LOG2N - 1);
  localparam int MAXW = max_w(W_BIT);
  typedef struct packed {
    logic                    v;
    logic signed [W_BIT-1:0] c;
    logic signed [W_BIT-1:0] s;
  } tw_t;
  logic signed [W_BIT-1:0] cos_tab [HALF];
  logic signed [W_BIT-1:0] sin_tab [HALF];
  tw_t d [RD_LAT];
  for (genvar i = 0; i < HALF; i++) begin : g_tab
    localparam real ANG = 2.0 * PI * i / (2.0 * HALF);
    localparam int  C   = round_int(MAXW * $cos(ANG));
    localparam int  S   = round_int(MAXW * $sin(ANG));
    assign cos_tab[i] = W_BIT'(C);
    assign sin_tab[i] = W_BIT'(S);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      d[0] <= {en, cos_tab[idx], sin_tab[idx]};
      for (int i = 1; i < RD_LAT; i++) d[i] <= d[i-1];
    end
  end
  assign vld = d[RD_LAT-1].v;
  assign cos = d[RD_LAT-1].c;
  assign sin = d[RD_LAT-1].s;
endmodule

// File: rtl/fht_addr_gen.sv
// fht_addr_gen: per-stage butterfly address, twiddle and delayed write-address sequencer
module fht_addr_gen #(
  parameter int LOG2N   = 4,
  parameter int W_BIT   = 16,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 1
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iSTART,
  input  logic                    iHOLD,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic [LOG2N-1:0]        oSTAGE,
  output logic                    oRD_EN,
  output logic                    oRD_BANK,
  output logic [LOG2N-1:0]        oRD_ADDR_0,
  output logic [LOG2N-1:0]        oRD_ADDR_1,
  output logic [LOG2N-1:0]        oRD_ADDR_2,
  output logic signed [W_BIT-1:0] oCOS,
  output logic signed [W_BIT-1:0] oSIN,
  output logic                    oTW_VLD,
  output logic                    oWR_EN,
  output logic                    oWR_BANK,
  output logic [LOG2N-1:0]        oWR_ADDR_0,
  output logic [LOG2N-1:0]        oWR_ADDR_1,
  output logic                    oRES_BANK
);
  import fht_pkg::*;
  localparam int AW       = LOG2N;
  localparam int CW       = LOG2N - 1;
  localparam int PIPE_LAT = RD_LAT + BUT_LAT;
  localparam int FW       = clog2_min1(PIPE_LAT);
  typedef struct packed {
    logic          vld;
    logic [AW-1:0] y0;
    logic [AW-1:0] y1;
    logic          bank;
  } wr_t;
  state_t        state, nxt;
  logic [AW-1:0] s, half, k, b, cnt_w;
  logic [CW-1:0] cnt, tw_idx;
  logic [FW-1:0] fcnt;
  logic          issue, last, flush_end, last_stage;
  wr_t           wp [PIPE_LAT];
  always_comb begin
    cnt_w      = AW'(cnt);
    half       = AW'(1) << s;
    k          = cnt_w & (half - AW'(1));
    b          = (cnt_w >> s) << (s + AW'(1));
    issue      = state == RUN && !iHOLD;
    last       = &cnt;
    flush_end  = fcnt == FW'(PIPE_LAT - 1);
    last_stage = s == AW'(LOG2N - 1);
    nxt = state == IDLE  ? (iSTART ? RUN : IDLE) :
          state == RUN   ? (issue && last ? FLUSH : RUN) :
          state == FLUSH ? (flush_end ? (last_stage ? DONE : RUN) : FLUSH) : IDLE;
  end
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= IDLE;
      s          <= '0;
      cnt        <= '0;
      fcnt       <= '0;
      tw_idx     <= '0;
      oRD_EN     <= 1'b0;
      oRD_BANK   <= 1'b0;
      oRD_ADDR_0 <= '0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wp[i] <= '0;
    end else begin
      state  <= nxt;
      oRD_EN <= issue;
      fcnt   <= state == FLUSH ? fcnt + FW'(1) : '0;
      if (state == IDLE && iSTART) begin
        s   <= '0;
        cnt <= '0;
      end
      // cnt wraps to 0 on the last issue of a stage, ready for the next one
      if (issue) begin
        cnt        <= cnt + CW'(1);
        oRD_BANK   <= s[0];
        oRD_ADDR_0 <= b + k;
        oRD_ADDR_1 <= b + half + k;
        oRD_ADDR_2 <= b + half + ((half - k) & (half - AW'(1)));
        tw_idx     <= CW'(k << (LOG2N - 1 - int'(s)));
      end
      if (state == FLUSH && flush_end && !last_stage) s <= s + AW'(1);
      wp[0] <= '{oRD_EN, oRD_ADDR_0, oRD_ADDR_1, ~oRD_BANK};
      for (int i = 1; i < PIPE_LAT; i++) wp[i] <= wp[i-1];
    end
  end
  fht_twiddle_rom #(.LOG2N(LOG2N), .W_BIT(W_BIT), .RD_LAT(RD_LAT)) u_rom (
    .clk (iCLK),
    .rst (iRESET),
    .en  (oRD_EN),
    .idx (tw_idx),
    .cos (oCOS),
    .sin (oSIN),
    .vld (oTW_VLD)
  );
  assign oBUSY      = state != IDLE;
  assign oDONE      = state == DONE;
  assign oSTAGE     = s;
  assign oRES_BANK  = oDONE && (LOG2N % 2 == 1);
  assign oWR_EN     = wp[PIPE_LAT-1].vld;
  assign oWR_ADDR_0 = wp[PIPE_LAT-1].y0;
  assign oWR_ADDR_1 = wp[PIPE_LAT-1].y1;
  assign oWR_BANK   = wp[PIPE_LAT-1].bank;
endmodule

// File: doc/fht_addr_gen.md
Name: fht_addr_gen

Overview:
- Address and twiddle sequencer that drives the FHT butterfly (fht_but) through all LOG2N radix-2 stages of an N-point Hartley transform.
- Each cycle it issues one butterfly: three read addresses (x0, x1, x2) into a ping-pong data RAM, plus the matching cos/sin coefficients.
- Write addresses for y0/y1 are delayed to line up with the butterfly output.
- Sits between the sample loader (already wrote bit-reversed input to bank 0) and the butterfly/RAM pair.

Parameters:
- LOG2N, 4, log2 of transform length N.
- W_BIT, 16, twiddle width, signed. MAX_W = 2^(W_BIT-1)-1.
- RD_LAT, 1, RAM read latency in cycles.
- BUT_LAT, 1, butterfly latency in cycles. PIPE_LAT = RD_LAT+BUT_LAT.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  synchronous reset, active-high.
- iSTART  in  1  start pulse; sampled only in IDLE.
- iHOLD  in  1  suppresses issue while high (RUN only).
- oBUSY  out  1  high from the cycle after accepted start through the DONE cycle.
- oDONE  out  1  one-cycle pulse when the last stage has drained.
- oSTAGE  out  LOG2N-bit  current stage s.
- oRD_EN  out  1  read issue strobe.
- oRD_BANK  out  1  bank read this stage, equal to s[0].
- oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2  out  LOG2N each  x0/x1/x2 addresses.
- oCOS, oSIN  out  W_BIT signed each  twiddle; valid RD_LAT cycles after the matching oRD_EN.
- oTW_VLD  out  1  qualifies oCOS/oSIN.
- oWR_EN  out  1  write strobe, PIPE_LAT cycles after the matching oRD_EN.
- oWR_BANK  out  1  equal to ~oRD_BANK of the issuing stage.
- oWR_ADDR_0, oWR_ADDR_1  out  LOG2N each  y0/y1 addresses.
- oRES_BANK  out  1  bank holding the final result, LOG2N[0]; valid when oDONE=1.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, delay-line valid bits cleared. Reset mid-operation aborts immediately. No writes emerge after reset, including writes that were in flight.
- FSM states:
  - IDLE: on iSTART go to RUN with s=0, cnt=0.
  - RUN: issue when !iHOLD, then cnt++. The issue at cnt=N/2-1 moves the FSM to FLUSH with fcnt=0.
  - FLUSH: lasts PIPE_LAT cycles. Then, if s=LOG2N-1, go to DONE; otherwise s++, cnt=0, return to RUN.
  - DONE: one cycle, oDONE=1, then IDLE.
- Address arithmetic for an issue at (s, cnt):
  - half = 2^s, k = cnt & (half-1), b = (cnt>>s)<<(s+1).
  - x0 = b+k; x1 = b+half+k; x2 = b+half+((half-k)&(half-1)). For k=0, x2 = x1.
  - y0 write = b+k; y1 write = b+half+k.
  - Twiddle index = k<<(LOG2N-1-s), range 0..N/2-1.
- Twiddle values: cos = round(MAX_W*cos(2*pi*idx/N)), sin likewise. Stage 0 therefore always gives cos=MAX_W, sin=0.
- Read outputs are registered: oRD_* change on the issue clock edge. oRD_EN=0 on hold or non-issue cycles; addresses hold their last value.
- Write path: a PIPE_LAT-deep shift register carrying {valid, y0, y1, bank}. It shifts every cycle regardless of iHOLD, so held cycles produce bubbles.
- FLUSH exists so every stage-s write lands before stage s+1 reads; no read/write bank overlap within a stage.
- iHOLD in FLUSH or DONE: no effect.
- iSTART while oBUSY: ignored.
- iSTART coinciding with oDONE: ignored; it must be re-asserted in IDLE.
- Busy duration with no holds: LOG2N*(N/2+PIPE_LAT) cycles plus 1 DONE cycle.

Decomposition:
- Package fht_pkg: state enum {IDLE, RUN, FLUSH, DONE}; MAX_W function of W_BIT; clog2 helpers.
- Sub-module fht_twiddle_rom: index in, registered cos/sin out.
  - Contents generated at elaboration from real math.
  - Internal delay of RD_LAT-1 extra stages so oCOS/oSIN align with RAM data.

Test Plan (LOG2N=4, W_BIT=16, RD_LAT=BUT_LAT=1):
1. Reset, then iSTART -> first issue: rd 0,1,1; next cycle cos=32767, sin=0, oTW_VLD=1; 2 cycles after issue oWR_EN=1 with wr 0,1, bank 1.
2. Stage 2, cnt=5 -> rd 9,13,15; twiddle idx 2 -> cos=23170, sin=23170; wr 9,13, read bank 0, write bank 1.
3. Full run, no hold -> oBUSY high 41 cycles; exactly 32 oRD_EN and 32 oWR_EN; single oDONE pulse; oRES_BANK=0; no write of stage s after the first read of stage s+1.
4. iHOLD high 3 cycles mid-stage 1 -> no oRD_EN and cnt frozen during hold; the two in-flight writes still appear; stage completes 3 cycles later.
5. iRESET asserted in stage 3 RUN -> next cycle all outputs 0, IDLE, no further oWR_EN; a new iSTART restarts at stage 0, rd 0,1,1.
6. iSTART pulsed during RUN and in the oDONE cycle -> ignored; oBUSY falls after DONE; second run starts only on a start issued in IDLE.
